multi_cycle_ctrl_fsm: RTL and testbench
=======================================

Name: multi_cycle_ctrl_fsm

Overview:
Sequencing controller for the multi-cycle CPU datapath. It replaces single-cycle combinational control with a registered IF/ID/EXE/MEM/WB state machine. It decodes op/func from the instruction register and drives every datapath enable and mux select per state. It also keeps a retired-instruction counter for bring-up and debug.

Parameters:
RA_IDX, 5'd31, register index written by jal; documents the RegDst=00 target.
CNT_W, 32, width of the retired-instruction counter.

Ports:
CLK  in  1  system clock; all state updates on rising edge.
Reset  in  1  asynchronous, active-low reset.
op  in  6  instruction[31:26] from the IR.
func  in  6  instruction[5:0] from the IR.
zero  in  1  ALU zero flag.
sign  in  1  ALU sign flag.
state  out  3  current state: IF=000, ID=001, EXE=010, MEM=011, WB=100, HALT=111.
PCWre  out  1  PC load enable, one cycle per instruction.
IRWre  out  1  IR load enable.
InsMemRW  out  1  constant 1 (instruction memory read).
RegWre  out  1  register-file write enable.
RegDst  out  2  write-register select: 00=RA_IDX, 01=rt, 10=rd.
WrRegDSrc  out  1  write data select: 0=PC+4, 1=DB.
ExtSel  out  1  extension mode: 1=sign, 0=zero.
ALUSrcA  out  1  ALU A select: 1=shamt, 0=rs.
ALUSrcB  out  1  ALU B select: 1=extended immediate, 0=rt.
ALUOp  out  3  000 add, 001 sub, 010 sll(B<<A), 011 or, 100 and, 110 slt signed.
DBDataSrc  out  1  DB select: 1=data-memory output, 0=ALU result.
mRD  out  1  data memory read.
mWR  out  1  data memory write.
PCSrc  out  2  next-PC select: 00=PC+4, 01=branch target, 10=rs, 11=jump target.
illegal  out  1  one-cycle pulse in ID for an unrecognised encoding.
instret  out  CNT_W  count of retired instructions.

Behaviour:
- Only state and instret are registered. All other outputs decode combinationally from state, op, func, zero and sign. Every output defaults to 0 in a state unless listed below; InsMemRW is always 1.
- Reset low, asynchronously: state=IF, instret=0. Outputs then show the IF decode: IRWre=1, PCWre=0, RegWre=0, mRD=0, mWR=0.
- Supported encodings:
  - R-type, op=000000: add 100000, sub 100010, and 100100, or 100101, slt 101010, sll 000000, jr 001000.
  - I-type: addiu 001001, andi 001100, ori 001101, slti 001010, lw 100011, sw 101011, beq 000100, bne 000101, bltz 000001.
  - J-type: j 000010, jal 000011.
  - halt 111111.
- IF: IRWre=1. Next state ID.
- ID:
  - j: PCSrc=11, PCWre=1; next IF.
  - jal: PCSrc=11, PCWre=1, RegWre=1, RegDst=00, WrRegDSrc=0; next IF.
  - jr: PCSrc=10, PCWre=1; next IF.
  - halt: next HALT, PCWre=0.
  - Illegal encoding: illegal=1, PCSrc=00, PCWre=1 (skip instruction); next IF.
  - All other instructions: next EXE.
- EXE:
  - ALUOp and ALUSrcA/B are held from EXE through WB for ALU instructions and through MEM for lw/sw.
  - ExtSel=1 for addiu, slti, lw, sw, beq, bne, bltz; ExtSel=0 for andi, ori.
  - ALUSrcA=1 only for sll. ALUSrcB=1 for all I-type ALU ops and lw/sw.
  - Branches use ALUOp=001, ALUSrcB=0. Branch is taken when:
    - beq: zero=1
    - bne: zero=0
    - bltz: sign=1
  - Branch resolution in EXE: PCWre=1; PCSrc=01 if taken, else 00. Next state IF.
  - lw/sw: next MEM. All others: next WB.
- MEM: ALUOp=000.
  - sw: mWR=1, PCWre=1, PCSrc=00; next IF.
  - lw: mRD=1; next WB.
- WB: RegWre=1, WrRegDSrc=1, PCWre=1, PCSrc=00; next IF.
  - R-type: RegDst=10, DBDataSrc=0.
  - I-type ALU: RegDst=01, DBDataSrc=0.
  - lw: RegDst=01, DBDataSrc=1, mRD=1.
- HALT: every enable is 0; the block stays in HALT until Reset.
- Instruction latency in cycles: j/jal/jr/illegal 2; branch 3; sw and ALU 4; lw 5.
- instret increments by 1 on every rising edge where PCWre=1 and illegal=0. It wraps modulo 2^CNT_W.
- Reset asserted mid-instruction aborts the instruction with no partial write. PCWre, RegWre and mWR drop to 0 immediately.
- PCWre is never high for more than one cycle per instruction. RegWre and mWR are never high together.

Test Plan:
1. Reset low, then release -> state=000, IRWre=1, PCWre=0, instret=0; next edge state=001.
2. add (op=0, func=100000) -> states IF, ID, EXE, WB, IF; RegWre=1 and RegDst=10 only in WB; ALUOp=000; PCWre=1 only in WB; instret goes 0->1.
3. lw -> 5 cycles; mRD=1 in MEM and WB; DBDataSrc=1, RegDst=01, ExtSel=1 in WB. sw -> mWR=1 in MEM, 4 cycles, RegWre never 1.
4. beq with zero=1 -> EXE: PCSrc=01, PCWre=1; with zero=0 -> PCSrc=00. bltz with sign=1 -> PCSrc=01. bne with zero=1 -> PCSrc=00.
5. jal -> ID: PCSrc=11, RegWre=1, RegDst=00, WrRegDSrc=0, PCWre=1; back in IF after 2 cycles. jr -> PCSrc=10.
6. halt -> state=111 and PCWre=0 for 10+ cycles. Reset low mid-EXE of add -> immediate state=000 and RegWre=0 with no WB cycle. op=110000 -> illegal pulse, instret unchanged.

Source files
------------

// File: rtl/multi_cycle_ctrl_fsm.sv
// Multi-cycle CPU control sequencer (IF/ID/EXE/MEM/WB/HALT).
// Decodes op/func from the IR and drives every datapath enable and mux
// select for the current state. Also keeps a retired-instruction counter.
// Ports:
//   CLK, Reset (async, active-low)
//   op, func         : IR fields [31:26] and [5:0]
//   zero, sign       : ALU flags used for branch resolution
//   state            : current FSM state
//   PCWre..PCSrc     : datapath controls, decoded from state/op/func/flags
//   illegal          : one-cycle pulse in ID for an unrecognised encoding
//   instret          : retired-instruction count (wraps)
module multi_cycle_ctrl_fsm #(
  parameter logic [4:0]  RA_IDX = 5'd31,
  parameter int unsigned CNT_W  = 32
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [5:0]       op,
  input  logic [5:0]       func,
  input  logic             zero,
  input  logic             sign,
  output logic [2:0]       state,
  output logic             PCWre,
  output logic             IRWre,
  output logic             InsMemRW,
  output logic             RegWre,
  output logic [1:0]       RegDst,
  output logic             WrRegDSrc,
  output logic             ExtSel,
  output logic             ALUSrcA,
  output logic             ALUSrcB,
  output logic [2:0]       ALUOp,
  output logic             DBDataSrc,
  output logic             mRD,
  output logic             mWR,
  output logic [1:0]       PCSrc,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  // jal writes the link register selected by RegDst=00; r0 would discard it
  if (RA_IDX == 5'd0) begin : g_ra_chk
    $error("RA_IDX must not be register 0");
  end

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BLTZ  = 6'b000001;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_JR  = 6'b001000;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_SLL = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b110;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_RS  = 2'b10;
  localparam logic [1:0] PC_JMP = 2'b11;

  localparam logic [1:0] DST_RA = 2'b00;
  localparam logic [1:0] DST_RT = 2'b01;
  localparam logic [1:0] DST_RD = 2'b10;

  typedef enum logic [2:0] {
    S_IF   = 3'b000,
    S_ID   = 3'b001,
    S_EXE  = 3'b010,
    S_MEM  = 3'b011,
    S_WB   = 3'b100,
    S_HALT = 3'b111
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_instret;

  // Instruction class decode
  logic w_rtype, w_add, w_sub, w_and, w_or, w_slt, w_sll, w_jr;
  logic w_addiu, w_andi, w_ori, w_slti, w_lw, w_sw;
  logic w_beq, w_bne, w_bltz, w_j, w_jal, w_halt;
  logic w_alu_r, w_alu_i, w_mem, w_br, w_legal, w_ext_sign, w_br_taken;
  logic [2:0] w_alu_op;

  assign w_rtype = (op == OP_RTYPE);
  assign w_add   = w_rtype && (func == FN_ADD);
  assign w_sub   = w_rtype && (func == FN_SUB);
  assign w_and   = w_rtype && (func == FN_AND);
  assign w_or    = w_rtype && (func == FN_OR);
  assign w_slt   = w_rtype && (func == FN_SLT);
  assign w_sll   = w_rtype && (func == FN_SLL);
  assign w_jr    = w_rtype && (func == FN_JR);
  assign w_addiu = (op == OP_ADDIU);
  assign w_andi  = (op == OP_ANDI);
  assign w_ori   = (op == OP_ORI);
  assign w_slti  = (op == OP_SLTI);
  assign w_lw    = (op == OP_LW);
  assign w_sw    = (op == OP_SW);
  assign w_beq   = (op == OP_BEQ);
  assign w_bne   = (op == OP_BNE);
  assign w_bltz  = (op == OP_BLTZ);
  assign w_j     = (op == OP_J);
  assign w_jal   = (op == OP_JAL);
  assign w_halt  = (op == OP_HALT);

  assign w_alu_r    = w_add | w_sub | w_and | w_or | w_slt | w_sll;
  assign w_alu_i    = w_addiu | w_andi | w_ori | w_slti;
  assign w_mem      = w_lw | w_sw;
  assign w_br       = w_beq | w_bne | w_bltz;
  assign w_legal    = w_alu_r | w_jr | w_alu_i | w_mem | w_br | w_j | w_jal | w_halt;
  assign w_ext_sign = w_addiu | w_slti | w_mem | w_br;
  assign w_br_taken = (w_beq & zero) | (w_bne & ~zero) | (w_bltz & sign);

  // ALU operation for the decoded instruction; branches compare via subtract
  always_comb begin
    w_alu_op = ALU_ADD;
    if (w_sub || w_br)          w_alu_op = ALU_SUB;
    else if (w_sll)             w_alu_op = ALU_SLL;
    else if (w_or || w_ori)     w_alu_op = ALU_OR;
    else if (w_and || w_andi)   w_alu_op = ALU_AND;
    else if (w_slt || w_slti)   w_alu_op = ALU_SLT;
  end

  // State register
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) r_state <= S_IF;
    else        r_state <= w_next_state;
  end

  // Next state and per-state control decode
  always_comb begin
    w_next_state = r_state;
    PCWre        = 1'b0;
    IRWre        = 1'b0;
    InsMemRW     = 1'b1;
    RegWre       = 1'b0;
    RegDst       = DST_RA;
    WrRegDSrc    = 1'b0;
    ExtSel       = 1'b0;
    ALUSrcA      = 1'b0;
    ALUSrcB      = 1'b0;
    ALUOp        = ALU_ADD;
    DBDataSrc    = 1'b0;
    mRD          = 1'b0;
    mWR          = 1'b0;
    PCSrc        = PC_SEQ;
    illegal      = 1'b0;

    case (r_state)
      S_IF: begin
        IRWre        = 1'b1;
        w_next_state = S_ID;
      end

      S_ID: begin
        if (w_j || w_jal) begin
          PCSrc        = PC_JMP;
          PCWre        = 1'b1;
          RegWre       = w_jal;  // link write: RegDst=RA, data=PC+4
          w_next_state = S_IF;
        end else if (w_jr) begin
          PCSrc        = PC_RS;
          PCWre        = 1'b1;
          w_next_state = S_IF;
        end else if (w_halt) begin
          w_next_state = S_HALT;
        end else if (!w_legal) begin
          // Skip the instruction; not counted as retired
          illegal      = 1'b1;
          PCWre        = 1'b1;
          w_next_state = S_IF;
        end else begin
          w_next_state = S_EXE;
        end
      end

      S_EXE: begin
        ExtSel = w_ext_sign;
        if (w_br) begin
          ALUOp        = w_alu_op;
          PCWre        = 1'b1;
          PCSrc        = w_br_taken ? PC_BR : PC_SEQ;
          w_next_state = S_IF;
        end else if (w_mem) begin
          ALUOp        = ALU_ADD;
          ALUSrcB      = 1'b1;
          w_next_state = S_MEM;
        end else if (w_alu_r || w_alu_i) begin
          ALUOp        = w_alu_op;
          ALUSrcA      = w_sll;
          ALUSrcB      = w_alu_i;
          w_next_state = S_WB;
        end else begin
          w_next_state = S_IF;
        end
      end

      S_MEM: begin
        ExtSel  = w_ext_sign;
        ALUOp   = ALU_ADD;
        ALUSrcB = 1'b1;
        if (w_sw) begin
          mWR          = 1'b1;
          PCWre        = 1'b1;
          w_next_state = S_IF;
        end else if (w_lw) begin
          mRD          = 1'b1;
          w_next_state = S_WB;
        end else begin
          w_next_state = S_IF;
        end
      end

      S_WB: begin
        RegWre       = 1'b1;
        WrRegDSrc    = 1'b1;
        PCWre        = 1'b1;
        ExtSel       = w_ext_sign;
        w_next_state = S_IF;
        if (w_lw) begin
          RegDst    = DST_RT;
          DBDataSrc = 1'b1;
          mRD       = 1'b1;
        end else if (w_alu_i) begin
          RegDst  = DST_RT;
          ALUOp   = w_alu_op;
          ALUSrcB = 1'b1;
        end else begin
          RegDst  = DST_RD;
          ALUOp   = w_alu_op;
          ALUSrcA = w_sll;
        end
      end

      S_HALT: w_next_state = S_HALT;

      default: w_next_state = S_IF;
    endcase
  end

  // Retired-instruction counter; skipped illegal encodings do not count
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset)                 r_instret <= '0;
    else if (PCWre && !illegal) r_instret <= r_instret + CNT_W'(1);
  end

  assign state   = r_state;
  assign instret = r_instret;

endmodule

// File: tb/tb_multi_cycle_ctrl_fsm.sv
// Directed bench for multi_cycle_ctrl_fsm: per-cycle control vectors for
// each instruction class, reset behaviour, halt and illegal encodings.
module tb_multi_cycle_ctrl_fsm;

  logic        CLK = 1'b0;
  logic        Reset = 1'b0;
  logic [5:0]  op = '0;
  logic [5:0]  func = '0;
  logic        zero = 1'b0;
  logic        sign = 1'b0;
  logic [2:0]  state;
  logic        PCWre, IRWre, InsMemRW, RegWre;
  logic [1:0]  RegDst;
  logic        WrRegDSrc, ExtSel, ALUSrcA, ALUSrcB;
  logic [2:0]  ALUOp;
  logic        DBDataSrc, mRD, mWR;
  logic [1:0]  PCSrc;
  logic        illegal;
  logic [31:0] instret;

  multi_cycle_ctrl_fsm #(.RA_IDX(5'd31), .CNT_W(32)) dut (
    .CLK(CLK), .Reset(Reset), .op(op), .func(func), .zero(zero), .sign(sign),
    .state(state), .PCWre(PCWre), .IRWre(IRWre), .InsMemRW(InsMemRW),
    .RegWre(RegWre), .RegDst(RegDst), .WrRegDSrc(WrRegDSrc), .ExtSel(ExtSel),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .DBDataSrc(DBDataSrc),
    .mRD(mRD), .mWR(mWR), .PCSrc(PCSrc), .illegal(illegal), .instret(instret)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [2:0] st;
    logic       pcw, irw, insm, rw;
    logic [1:0] rdst;
    logic       wsrc, ext, srca, srcb;
    logic [2:0] aluop;
    logic       dbs, mrd, mwr;
    logic [1:0] pcsrc;
    logic       ill;
  } ctl_t;

  localparam logic [2:0] ST_IF = 3'b000, ST_ID = 3'b001, ST_EXE = 3'b010,
                         ST_MEM = 3'b011, ST_WB = 3'b100, ST_HALT = 3'b111;

  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] exp_ir = '0;

  function automatic ctl_t observe();
    ctl_t c;
    c.st = state; c.pcw = PCWre; c.irw = IRWre; c.insm = InsMemRW;
    c.rw = RegWre; c.rdst = RegDst; c.wsrc = WrRegDSrc; c.ext = ExtSel;
    c.srca = ALUSrcA; c.srcb = ALUSrcB; c.aluop = ALUOp; c.dbs = DBDataSrc;
    c.mrd = mRD; c.mwr = mWR; c.pcsrc = PCSrc; c.ill = illegal;
    return c;
  endfunction

  // All-quiet vector for a state; IF always loads the IR
  function automatic ctl_t base(input logic [2:0] st);
    ctl_t c;
    c = '0;
    c.st = st;
    c.insm = 1'b1;
    c.irw = (st == ST_IF);
    return c;
  endfunction

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  // Leaves the bench at a negedge with reset released and the FSM in IF
  task automatic do_reset();
    @(negedge CLK);
    Reset = 1'b0; op = '0; func = '0; zero = 1'b0; sign = 1'b0;
    @(negedge CLK);
    Reset = 1'b1;
    #1;
    exp_ir = '0;
  endtask

  task automatic test_reset();
    ctl_t obs;
    @(negedge CLK);
    Reset = 1'b0;
    #1;
    obs = observe(); n_chk++;
    if (obs !== base(ST_IF)) begin
      n_err++; $display("FAIL reset_decode got %h exp %h", obs, base(ST_IF));
    end
    n_chk++;
    if (instret !== 32'd0) begin
      n_err++; $display("FAIL reset_instret got %0d exp 0", instret);
    end
    @(negedge CLK);
    Reset = 1'b1;
    #1;
    n_chk++;
    if (state !== ST_IF) begin
      n_err++; $display("FAIL reset_release_state got %b exp %b", state, ST_IF);
    end
    tick();
    n_chk++;
    if (state !== ST_ID) begin
      n_err++; $display("FAIL reset_first_edge got %b exp %b", state, ST_ID);
    end
    do_reset();
  endtask

  task automatic test_alu();
    logic [5:0] t_op [5];
    logic [5:0] t_fn [5];
    logic [2:0] t_alu [5];
    logic       t_i [5];
    logic       t_sa [5];
    logic       t_ext [5];
    ctl_t       e [4];
    ctl_t       obs;
    t_op  = '{6'b000000, 6'b000000, 6'b000000, 6'b001101, 6'b001010};
    t_fn  = '{6'b100000, 6'b100010, 6'b000000, 6'b000000, 6'b000000};
    t_alu = '{3'b000,    3'b001,    3'b010,    3'b011,    3'b110};
    t_i   = '{1'b0,      1'b0,      1'b0,      1'b1,      1'b1};
    t_sa  = '{1'b0,      1'b0,      1'b1,      1'b0,      1'b0};
    t_ext = '{1'b0,      1'b0,      1'b0,      1'b0,      1'b1};
    for (int k = 0; k < 5; k++) begin
      e[0] = base(ST_IF);
      e[1] = base(ST_ID);
      e[2] = base(ST_EXE);
      e[2].aluop = t_alu[k]; e[2].srca = t_sa[k]; e[2].srcb = t_i[k]; e[2].ext = t_ext[k];
      e[3] = e[2];
      e[3].st = ST_WB; e[3].rw = 1'b1; e[3].wsrc = 1'b1; e[3].pcw = 1'b1;
      e[3].rdst = t_i[k] ? 2'b01 : 2'b10;
      op = t_op[k]; func = t_fn[k];
      #1;
      for (int i = 0; i < 4; i++) begin
        obs = observe(); n_chk++;
        if (obs !== e[i]) begin
          n_err++; $display("FAIL alu%0d_cyc%0d got %h exp %h", k, i, obs, e[i]);
        end
        tick();
      end
      exp_ir++;
      n_chk++;
      if (state !== ST_IF || instret !== exp_ir) begin
        n_err++; $display("FAIL alu%0d_retire state %b instret %0d exp %b %0d", k, state, instret, ST_IF, exp_ir);
      end
    end
  endtask

  task automatic test_mem();
    ctl_t e [5];
    ctl_t obs;
    int   n;
    for (int k = 0; k < 2; k++) begin
      e[0] = base(ST_IF);
      e[1] = base(ST_ID);
      e[2] = base(ST_EXE); e[2].ext = 1'b1; e[2].srcb = 1'b1;
      e[3] = e[2]; e[3].st = ST_MEM;
      e[4] = base(ST_WB);
      if (k == 0) begin
        op = 6'b100011; n = 5;
        e[3].mrd = 1'b1;
        e[4].rw = 1'b1; e[4].wsrc = 1'b1; e[4].pcw = 1'b1; e[4].rdst = 2'b01;
        e[4].dbs = 1'b1; e[4].mrd = 1'b1; e[4].ext = 1'b1;
      end else begin
        op = 6'b101011; n = 4;
        e[3].mwr = 1'b1; e[3].pcw = 1'b1;
      end
      func = 6'b000111;
      #1;
      for (int i = 0; i < n; i++) begin
        obs = observe(); n_chk++;
        if (obs !== e[i]) begin
          n_err++; $display("FAIL mem%0d_cyc%0d got %h exp %h", k, i, obs, e[i]);
        end
        tick();
      end
      exp_ir++;
      n_chk++;
      if (state !== ST_IF || instret !== exp_ir) begin
        n_err++; $display("FAIL mem%0d_retire state %b instret %0d exp %b %0d", k, state, instret, ST_IF, exp_ir);
      end
    end
  endtask

  task automatic test_branch();
    logic [5:0] t_op [6];
    logic       t_z [6];
    logic       t_s [6];
    logic       t_tk [6];
    ctl_t       e [3];
    ctl_t       obs;
    t_op = '{6'b000100, 6'b000100, 6'b000001, 6'b000001, 6'b000101, 6'b000101};
    t_z  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    t_s  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    t_tk = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 6; k++) begin
      e[0] = base(ST_IF);
      e[1] = base(ST_ID);
      e[2] = base(ST_EXE);
      e[2].ext = 1'b1; e[2].aluop = 3'b001; e[2].pcw = 1'b1;
      e[2].pcsrc = t_tk[k] ? 2'b01 : 2'b00;
      op = t_op[k]; func = 6'b100000; zero = t_z[k]; sign = t_s[k];
      #1;
      for (int i = 0; i < 3; i++) begin
        obs = observe(); n_chk++;
        if (obs !== e[i]) begin
          n_err++; $display("FAIL br%0d_cyc%0d got %h exp %h", k, i, obs, e[i]);
        end
        tick();
      end
      exp_ir++;
      n_chk++;
      if (state !== ST_IF || instret !== exp_ir) begin
        n_err++; $display("FAIL br%0d_retire state %b instret %0d exp %b %0d", k, state, instret, ST_IF, exp_ir);
      end
    end
    zero = 1'b0; sign = 1'b0;
  endtask

  task automatic test_jump();
    logic [5:0] t_op [3];
    logic [5:0] t_fn [3];
    logic [1:0] t_pc [3];
    logic       t_rw [3];
    ctl_t       e [2];
    ctl_t       obs;
    t_op = '{6'b000010, 6'b000011, 6'b000000};
    t_fn = '{6'b100000, 6'b100000, 6'b001000};
    t_pc = '{2'b11, 2'b11, 2'b10};
    t_rw = '{1'b0, 1'b1, 1'b0};
    for (int k = 0; k < 3; k++) begin
      e[0] = base(ST_IF);
      e[1] = base(ST_ID);
      e[1].pcw = 1'b1; e[1].pcsrc = t_pc[k]; e[1].rw = t_rw[k];
      op = t_op[k]; func = t_fn[k];
      #1;
      for (int i = 0; i < 2; i++) begin
        obs = observe(); n_chk++;
        if (obs !== e[i]) begin
          n_err++; $display("FAIL jmp%0d_cyc%0d got %h exp %h", k, i, obs, e[i]);
        end
        tick();
      end
      exp_ir++;
      n_chk++;
      if (state !== ST_IF || instret !== exp_ir) begin
        n_err++; $display("FAIL jmp%0d_retire state %b instret %0d exp %b %0d", k, state, instret, ST_IF, exp_ir);
      end
    end
  endtask

  task automatic test_illegal();
    logic [5:0] t_op [2];
    logic [5:0] t_fn [2];
    ctl_t       e [2];
    ctl_t       obs;
    t_op = '{6'b110000, 6'b000000};
    t_fn = '{6'b100000, 6'b000001};
    for (int k = 0; k < 2; k++) begin
      e[0] = base(ST_IF);
      e[1] = base(ST_ID); e[1].ill = 1'b1; e[1].pcw = 1'b1;
      op = t_op[k]; func = t_fn[k];
      #1;
      for (int i = 0; i < 2; i++) begin
        obs = observe(); n_chk++;
        if (obs !== e[i]) begin
          n_err++; $display("FAIL ill%0d_cyc%0d got %h exp %h", k, i, obs, e[i]);
        end
        tick();
      end
      n_chk++;
      if (state !== ST_IF || instret !== exp_ir) begin
        n_err++; $display("FAIL ill%0d_count state %b instret %0d exp %b %0d", k, state, instret, ST_IF, exp_ir);
      end
    end
  endtask

  task automatic test_back_to_back();
    ctl_t obs;
    // add then sw with no gap: IF of the second follows WB of the first
    op = 6'b000000; func = 6'b100000;
    #1;
    for (int i = 0; i < 4; i++) tick();
    op = 6'b101011;
    #1;
    obs = observe(); n_chk++;
    if (obs !== base(ST_IF)) begin
      n_err++; $display("FAIL b2b_if got %h exp %h", obs, base(ST_IF));
    end
    for (int i = 0; i < 4; i++) tick();
    exp_ir += 2;
    n_chk++;
    if (state !== ST_IF || instret !== exp_ir) begin
      n_err++; $display("FAIL b2b_retire state %b instret %0d exp %b %0d", state, instret, ST_IF, exp_ir);
    end
  endtask

  task automatic test_halt();
    ctl_t obs;
    op = 6'b111111; func = 6'b000000;
    #1;
    tick();
    obs = observe(); n_chk++;
    if (obs !== base(ST_ID)) begin
      n_err++; $display("FAIL halt_id got %h exp %h", obs, base(ST_ID));
    end
    for (int i = 0; i < 12; i++) begin
      tick();
      if (i == 3) op = 6'b000010;  // IR changes must not wake the FSM
      #1;
      obs = observe(); n_chk++;
      if (obs !== base(ST_HALT) || instret !== exp_ir) begin
        n_err++; $display("FAIL halt_hold%0d got %h exp %h instret %0d", i, obs, base(ST_HALT), instret);
      end
    end
    do_reset();
    n_chk++;
    if (state !== ST_IF || instret !== 32'd0) begin
      n_err++; $display("FAIL halt_exit state %b instret %0d exp %b 0", state, instret, ST_IF);
    end
  endtask

  task automatic test_reset_mid();
    ctl_t obs;
    // Retire one jump so the counter is nonzero before the abort
    op = 6'b000010; func = '0;
    #1;
    tick(); tick();
    op = 6'b000000; func = 6'b100000;
    #1;
    tick(); tick();
    n_chk++;
    if (state !== ST_EXE || instret !== 32'd1) begin
      n_err++; $display("FAIL rstmid_pre state %b instret %0d exp %b 1", state, instret, ST_EXE);
    end
    Reset = 1'b0;
    #1;
    obs = observe(); n_chk++;
    if (obs !== base(ST_IF) || instret !== 32'd0) begin
      n_err++; $display("FAIL rstmid_abort got %h instret %0d exp %h 0", obs, instret, base(ST_IF));
    end
    @(negedge CLK);
    Reset = 1'b1;
    #1;
    tick();
    n_chk++;
    if (state !== ST_ID || RegWre !== 1'b0 || instret !== 32'd0) begin
      n_err++; $display("FAIL rstmid_resume state %b RegWre %b instret %0d exp %b 0 0", state, RegWre, instret, ST_ID);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_mem();
    test_branch();
    test_jump();
    test_illegal();
    test_back_to_back();
    test_halt();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
